// File: rtl/data_loader_pkg.sv
// -----------------------------------------------------------------------------
// data_loader_pkg
// Shared definitions for the data_loader_split bridge write sink:
//   - FSM state encodings (IDLE / EMIT)
//   - normalise_bytes(): reorders a 32-bit bridge word into b3..b2..b1..b0
//   - helpers deriving words-per-entry and word-index width from the
//     output word size, plus legality checks used at elaboration
// -----------------------------------------------------------------------------
package data_loader_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    // Bytes of one captured bridge write, lowest-addressed byte in b0.
    typedef struct packed {
        logic [7:0] b3;
        logic [7:0] b2;
        logic [7:0] b1;
        logic [7:0] b0;
    } entry_bytes_t;

    // little=1: data[7:0] is byte 0. little=0: data[31:24] is byte 0.
    function automatic entry_bytes_t normalise_bytes(input logic [31:0] data,
                                                     input logic        little);
        entry_bytes_t b;
        if (little) begin
            b = data;
        end else begin
            b = {data[7:0], data[15:8], data[23:16], data[31:24]};
        end
        return b;
    endfunction

    function automatic int unsigned words_per_entry(input int unsigned word_bytes);
        return (word_bytes == 0) ? 1 : (4 / word_bytes);
    endfunction

    function automatic int unsigned index_bits(input int unsigned word_bytes);
        int unsigned bits;
        case (word_bytes)
            1:       bits = 2;
            2:       bits = 1;
            default: bits = 0;
        endcase
        return bits;
    endfunction

    function automatic bit legal_word_size(input int unsigned word_bytes);
        return (word_bytes == 1) || (word_bytes == 2) || (word_bytes == 4);
    endfunction

    function automatic bit legal_fifo_depth(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/data_loader_split_fifo.sv
// -----------------------------------------------------------------------------
// data_loader_fifo
// Synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous reset, active-high (empties the FIFO)
//   push_i   write data_i; accepted when not full, or when full and a pop
//            happens on the same edge
//   data_i   entry to write
//   pop_i    remove the head entry (ignored when empty)
//   data_o   head entry (valid while !empty_o)
//   full_o   DEPTH entries stored
//   empty_o  no entries stored
// -----------------------------------------------------------------------------
module data_loader_fifo #(
    parameter int unsigned WIDTH = 46,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // When full, the slot being written is the one being popped this edge;
    // the head is read combinationally before the edge, so this is safe.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed through count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/data_loader_split.sv
// -----------------------------------------------------------------------------
// data_loader_split
// APF bridge write sink. Captures 32-bit bridge writes whose address falls in
// the 256 MB region selected by ADDRESS_MASK_UPPER_4, buffers them in a FIFO,
// and replays each one as 1, 2 or 4 narrower memory writes over a
// valid/ready handshake so slow memories can stall without losing data.
// Ports:
//   clk_74a               bridge clock (only clock)
//   reset                 asynchronous reset, active-high
//   bridge_wr             bridge write strobe, one cycle per 32-bit write
//   bridge_endian_little  1: bridge_wr_data[7:0] is byte 0; 0: [31:24] is byte 0
//   bridge_addr           bridge byte address
//   bridge_wr_data        bridge write data
//   write_en              output word valid
//   write_addr            output word address (byte address / word size)
//   write_data            output word, lowest-addressed byte in [7:0]
//   write_ready           memory accepts the word when write_en && write_ready
//   busy                  FIFO non-empty or an output word pending
//   overflow              sticky: a matching write was dropped (reset clears)
// -----------------------------------------------------------------------------
module data_loader_split
    import data_loader_pkg::*;
#(
    parameter logic [3:0]  ADDRESS_MASK_UPPER_4 = 4'h0,
    parameter int unsigned ADDRESS_SIZE         = 14,
    parameter int unsigned OUTPUT_WORD_SIZE     = 2,
    parameter int unsigned FIFO_DEPTH           = 4
) (
    input  logic                          clk_74a,
    input  logic                          reset,
    input  logic                          bridge_wr,
    input  logic                          bridge_endian_little,
    input  logic [31:0]                   bridge_addr,
    input  logic [31:0]                   bridge_wr_data,
    output logic                          write_en,
    output logic [ADDRESS_SIZE-1:0]       write_addr,
    output logic [8*OUTPUT_WORD_SIZE-1:0] write_data,
    input  logic                          write_ready,
    output logic                          busy,
    output logic                          overflow
);

    localparam int unsigned WORDS_PER_ENTRY = words_per_entry(OUTPUT_WORD_SIZE);
    localparam int unsigned INDEX_BITS      = index_bits(OUTPUT_WORD_SIZE);
    localparam int unsigned IDX_W           = (INDEX_BITS == 0) ? 1 : INDEX_BITS;
    localparam int unsigned WORD_W          = 8 * OUTPUT_WORD_SIZE;
    localparam int unsigned ENTRY_W         = ADDRESS_SIZE + 32;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS_PER_ENTRY - 1);

    generate
        if (!legal_word_size(OUTPUT_WORD_SIZE)) begin : g_bad_word_size
            $error("data_loader_split: OUTPUT_WORD_SIZE must be 1, 2 or 4");
        end
        if (!legal_fifo_depth(FIFO_DEPTH)) begin : g_bad_fifo_depth
            $error("data_loader_split: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // Word k of an entry sits at bits [k*W+W-1 : k*W] of b3..b0.
    function automatic logic [WORD_W-1:0] pick_word(input logic [31:0]      bytes,
                                                     input logic [IDX_W-1:0] k);
        return WORD_W'(bytes >> (int'(k) * WORD_W));
    endfunction

    // {entry_addr, k} truncated to ADDRESS_SIZE; wraps silently.
    function automatic logic [ADDRESS_SIZE-1:0] make_addr(input logic [ADDRESS_SIZE-1:0] ea,
                                                          input logic [IDX_W-1:0]        k);
        return ADDRESS_SIZE'(({2'b00, ea} << INDEX_BITS) | (ADDRESS_SIZE+2)'(k));
    endfunction

    // Capture side
    logic                    match;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ENTRY_W-1:0]      fifo_wdata;
    logic [ENTRY_W-1:0]      fifo_rdata;
    logic [ADDRESS_SIZE-1:0] fifo_addr;
    logic [31:0]             fifo_bytes;
    logic                    unused_addr;

    assign match       = bridge_wr && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);
    assign fifo_push   = match;
    assign fifo_wdata  = {bridge_addr[ADDRESS_SIZE+1:2],
                          normalise_bytes(bridge_wr_data, bridge_endian_little)};
    assign fifo_addr   = fifo_rdata[ENTRY_W-1:32];
    assign fifo_bytes  = fifo_rdata[31:0];
    assign unused_addr = ^bridge_addr;

    data_loader_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_74a),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Emit side
    logic [0:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [31:0]             bytes_q, bytes_d;
    logic [ADDRESS_SIZE-1:0] eaddr_q, eaddr_d;
    logic                    write_en_q, write_en_d;
    logic [ADDRESS_SIZE-1:0] write_addr_q, write_addr_d;
    logic [WORD_W-1:0]       write_data_q, write_data_d;
    logic                    overflow_q, overflow_d;
    logic                    load_new;
    logic                    load_next;
    logic [31:0]             src_bytes;
    logic [ADDRESS_SIZE-1:0] src_addr;
    logic [IDX_W-1:0]        src_idx;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bytes_d      = bytes_q;
        eaddr_d      = eaddr_q;
        write_en_d   = write_en_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        load_new     = 1'b0;
        load_next    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load_new = 1'b1;
                end
            end
            ST_EMIT: begin
                if (write_ready) begin
                    if (idx_q != LAST_IDX) begin
                        load_next = 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next entry: no idle cycle.
                        load_new = 1'b1;
                    end else begin
                        write_en_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fifo_pop  = load_new;
        src_bytes = load_new ? fifo_bytes : bytes_q;
        src_addr  = load_new ? fifo_addr : eaddr_q;
        src_idx   = load_new ? '0 : (idx_q + IDX_W'(1));

        if (load_new || load_next) begin
            bytes_d      = src_bytes;
            eaddr_d      = src_addr;
            idx_d        = src_idx;
            write_en_d   = 1'b1;
            write_addr_d = make_addr(src_addr, src_idx);
            write_data_d = pick_word(src_bytes, src_idx);
            state_d      = ST_EMIT;
        end

        overflow_d = overflow_q | (match && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            bytes_q      <= '0;
            eaddr_q      <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bytes_q      <= bytes_d;
            eaddr_q      <= eaddr_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            overflow_q   <= overflow_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign overflow   = overflow_q;
    assign busy       = !fifo_empty || write_en_q;

endmodule

// File: tb/tb_data_loader_split.sv
// -----------------------------------------------------------------------------
// tb_data_loader_split
// Directed bench for data_loader_split. Three instances cover the 2-byte,
// 1-byte (depth-2 FIFO) and 4-byte output configurations; each has its own
// write strobe and ready so traffic on one does not disturb the others.
// -----------------------------------------------------------------------------
module tb_data_loader_split;

    logic        clk = 1'b0;
    logic        rst;
    logic        little;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        wr2, rdy2, en2, busy2, ovf2;
    logic [13:0] a2;
    logic [15:0] d2;

    logic        wr1, rdy1, en1, busy1, ovf1;
    logic [13:0] a1;
    logic [7:0]  d1;

    logic        wr4, rdy4, en4, busy4, ovf4;
    logic [13:0] a4;
    logic [31:0] d4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_loader_split #(
        .ADDRESS_MASK_UPPER_4 (4'h0),
        .ADDRESS_SIZE         (14),
        .OUTPUT_WORD_SIZE     (2),
        .FIFO_DEPTH           (4)
    ) u_w2 (
        .clk_74a              (clk),
        .reset                (rst),
        .bridge_wr            (wr2),
        .bridge_endian_little (little),
        .bridge_addr          (addr),
        .bridge_wr_data       (wdata),
        .write_en             (en2),
        .write_addr           (a2),
        .write_data           (d2),
        .write_ready          (rdy2),
        .busy                 (busy2),
        .overflow             (ovf2)
    );

    data_loader_split #(
        .ADDRESS_MASK_UPPER_4 (4'h0),
        .ADDRESS_SIZE         (14),
        .OUTPUT_WORD_SIZE     (1),
        .FIFO_DEPTH           (2)
    ) u_w1 (
        .clk_74a              (clk),
        .reset                (rst),
        .bridge_wr            (wr1),
        .bridge_endian_little (little),
        .bridge_addr          (addr),
        .bridge_wr_data       (wdata),
        .write_en             (en1),
        .write_addr           (a1),
        .write_data           (d1),
        .write_ready          (rdy1),
        .busy                 (busy1),
        .overflow             (ovf1)
    );

    data_loader_split #(
        .ADDRESS_MASK_UPPER_4 (4'h0),
        .ADDRESS_SIZE         (14),
        .OUTPUT_WORD_SIZE     (4),
        .FIFO_DEPTH           (4)
    ) u_w4 (
        .clk_74a              (clk),
        .reset                (rst),
        .bridge_wr            (wr4),
        .bridge_endian_little (little),
        .bridge_addr          (addr),
        .bridge_wr_data       (wdata),
        .write_en             (en4),
        .write_addr           (a4),
        .write_data           (d4),
        .write_ready          (rdy4),
        .busy                 (busy4),
        .overflow             (ovf4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w2(input string tag, input logic e, input logic [13:0] a,
                          input logic [15:0] d);
        chk({tag, ".en"}, 64'(en2), 64'(e));
        if (e) begin
            chk({tag, ".addr"}, 64'(a2), 64'(a));
            chk({tag, ".data"}, 64'(d2), 64'(d));
        end
    endtask

    task automatic chk_w1(input string tag, input logic e, input logic [13:0] a,
                          input logic [7:0] d);
        chk({tag, ".en"}, 64'(en1), 64'(e));
        if (e) begin
            chk({tag, ".addr"}, 64'(a1), 64'(a));
            chk({tag, ".data"}, 64'(d1), 64'(d));
        end
    endtask

    // One bridge write into u_w2 with ready held high; expects two words
    // on the cycles after the one-cycle capture latency.
    task automatic w2_write(input string tag, input logic [31:0] ba, input logic [31:0] bd,
                            input logic le, input logic [13:0] ea0,
                            input logic [15:0] ed0, input logic [15:0] ed1);
        rdy2 = 1'b1; little = le; addr = ba; wdata = bd; wr2 = 1'b1;
        tick;
        wr2 = 1'b0;
        chk({tag, ".lat_en"}, 64'(en2), 64'd0);
        chk({tag, ".lat_busy"}, 64'(busy2), 64'd1);
        tick;
        chk_w2({tag, ".w0"}, 1'b1, ea0, ed0);
        tick;
        chk_w2({tag, ".w1"}, 1'b1, ea0 + 14'd1, ed1);
        tick;
        chk_w2({tag, ".done"}, 1'b0, '0, '0);
        chk({tag, ".idle_busy"}, 64'(busy2), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ovf_words [3];
        logic [7:0]  exp_byte;

        rst = 1'b1; little = 1'b1; addr = '0; wdata = '0;
        wr2 = 1'b0; wr1 = 1'b0; wr4 = 1'b0;
        rdy2 = 1'b0; rdy1 = 1'b0; rdy4 = 1'b0;
        tick;
        tick;

        // Reset state
        chk("rst.en2", 64'(en2), 64'd0);
        chk("rst.a2", 64'(a2), 64'd0);
        chk("rst.d2", 64'(d2), 64'd0);
        chk("rst.busy2", 64'(busy2), 64'd0);
        chk("rst.ovf2", 64'(ovf2), 64'd0);
        chk("rst.en1", 64'(en1), 64'd0);
        chk("rst.d4", 64'(d4), 64'd0);
        chk("rst.ovf1", 64'(ovf1), 64'd0);
        rst = 1'b0;
        tick;

        // 2-byte words: little, big endian, and address wrap at 2^14 words
        w2_write("le",   32'h0000_0010, 32'hAABB_CCDD, 1'b1, 14'h0008, 16'hCCDD, 16'hAABB);
        w2_write("be",   32'h0000_0010, 32'hAABB_CCDD, 1'b0, 14'h0008, 16'hBBAA, 16'hDDCC);
        w2_write("wrap", 32'h0000_FFFC, 32'h1234_5678, 1'b1, 14'h3FFE, 16'h5678, 16'h1234);

        // 1-byte words with ready toggling: each byte held until accepted
        rdy1 = 1'b0; little = 1'b1; addr = 32'h0000_0004; wdata = 32'h1122_3344; wr1 = 1'b1;
        tick;
        wr1 = 1'b0;
        tick;
        chk_w1("tog0", 1'b1, 14'd4, 8'h44); rdy1 = 1'b1; tick;
        chk_w1("tog1", 1'b1, 14'd5, 8'h33); rdy1 = 1'b0; tick;
        chk_w1("tog2", 1'b1, 14'd5, 8'h33); rdy1 = 1'b1; tick;
        chk_w1("tog3", 1'b1, 14'd6, 8'h22); rdy1 = 1'b0; tick;
        chk_w1("tog4", 1'b1, 14'd6, 8'h22); rdy1 = 1'b1; tick;
        chk_w1("tog5", 1'b1, 14'd7, 8'h11); tick;
        chk_w1("tog6", 1'b0, '0, '0);
        chk("tog.busy", 64'(busy1), 64'd0);

        // Overflow on depth-2 FIFO with ready low. The first write moves
        // straight into the output stage, the next two fill the FIFO, and the
        // fourth is dropped.
        ovf_words[0] = 32'h0102_0304;
        ovf_words[1] = 32'h0506_0708;
        ovf_words[2] = 32'h090A_0B0C;
        rdy1 = 1'b0; little = 1'b1; wr1 = 1'b1;
        addr = 32'h0000_0020; wdata = ovf_words[0]; tick;
        addr = 32'h0000_0024; wdata = ovf_words[1]; tick;
        addr = 32'h0000_0028; wdata = ovf_words[2]; tick;
        chk("ovf.before", 64'(ovf1), 64'd0);
        addr = 32'h0000_002C; wdata = 32'hDEAD_BEEF; tick;
        wr1 = 1'b0;
        chk("ovf.set", 64'(ovf1), 64'd1);
        chk_w1("ovf.hold", 1'b1, 14'h20, 8'h04);
        rdy1 = 1'b1;
        for (int i = 1; i < 12; i++) begin
            tick;
            exp_byte = 8'((ovf_words[i / 4] >> (8 * (i % 4))) & 32'hFF);
            chk_w1($sformatf("ovf.w%0d", i), 1'b1, 14'(32'h20 + i), exp_byte);
        end
        tick;
        chk_w1("ovf.end", 1'b0, '0, '0);
        chk("ovf.sticky", 64'(ovf1), 64'd1);
        tick;
        chk_w1("ovf.nofourth", 1'b0, '0, '0);

        // Non-matching region is ignored; then 4-byte words
        rdy4 = 1'b1; little = 1'b1; addr = 32'h1000_0000; wdata = 32'hDEAD_BEEF; wr4 = 1'b1;
        tick;
        wr4 = 1'b0;
        chk("nomatch.busy0", 64'(busy4), 64'd0);
        tick;
        chk("nomatch.en", 64'(en4), 64'd0);
        chk("nomatch.busy1", 64'(busy4), 64'd0);
        addr = 32'h0000_0000; wdata = 32'hCAFE_F00D; wr4 = 1'b1;
        tick;
        wr4 = 1'b0;
        tick;
        chk("w4.en", 64'(en4), 64'd1);
        chk("w4.addr", 64'(a4), 64'd0);
        chk("w4.data", 64'(d4), 64'hCAFE_F00D);
        tick;
        chk("w4.done", 64'(en4), 64'd0);
        little = 1'b0; addr = 32'h0001_0004; wdata = 32'h5566_7788; wr4 = 1'b1;
        tick;
        wr4 = 1'b0;
        tick;
        chk("w4wrap.addr", 64'(a4), 64'd1);
        chk("w4wrap.data", 64'(d4), 64'h8877_6655);
        tick;
        chk("w4wrap.done", 64'(en4), 64'd0);

        // Reset while emitting with two entries queued
        rdy2 = 1'b0; little = 1'b1; wr2 = 1'b1;
        addr = 32'h0000_0040; wdata = 32'h0A0B_0C0D; tick;
        addr = 32'h0000_0044; tick;
        addr = 32'h0000_0048; tick;
        wr2 = 1'b0;
        tick;
        chk_w2("mid.emit", 1'b1, 14'h20, 16'h0C0D);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.en_async", 64'(en2), 64'd0);
        chk("mid.busy", 64'(busy2), 64'd0);
        chk("mid.a2", 64'(a2), 64'd0);
        chk("mid.ovf1_clr", 64'(ovf1), 64'd0);
        tick;
        rst = 1'b0;
        rdy2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("post.en%0d", i), 64'(en2), 64'd0);
            chk($sformatf("post.busy%0d", i), 64'(busy2), 64'd0);
        end
        w2_write("after", 32'h0000_0050, 32'h1111_2222, 1'b1, 14'h0028, 16'h2222, 16'h1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
